// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: shared widths, FSM states and grant-source encoding for the writeback arbiter
package reg_wb_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    typedef enum logic {NORM, BOOST} state_e;
    typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_MEM} src_e;
endpackage

// File: rtl/reg_wb_arbiter_if.sv
// reg_wb_arbiter_if: ALU/load writeback requests plus the register-file write port
interface reg_wb_arbiter_if #(
    parameter int DATA_W = reg_wb_pkg::DATA_W,
    parameter int ADDR_W = reg_wb_pkg::ADDR_W
);
    logic              hold;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_dr;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_dr;
    logic [DATA_W-1:0] mem_data;
    logic              RegW;
    logic [ADDR_W-1:0] DR;
    logic [DATA_W-1:0] data_write;
    logic              alu_boost;
    modport master (
        output hold, alu_valid, alu_dr, alu_data, mem_valid, mem_dr, mem_data,
        input  alu_ready, mem_ready, RegW, DR, data_write, alu_boost
    );
    modport slave (
        input  hold, alu_valid, alu_dr, alu_data, mem_valid, mem_dr, mem_data,
        output alu_ready, mem_ready, RegW, DR, data_write, alu_boost
    );
endinterface

// File: rtl/reg_wb_starve_ctr.sv
// reg_wb_starve_ctr: saturating count of consecutive ALU denials; hit flags the denial that reaches MAX
module reg_wb_starve_ctr #(
    parameter int MAX = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic hit_o
);
    localparam int W = $clog2(MAX + 1);
    logic [W-1:0] cnt_q, cnt_d;
    // clear wins over increment; counting stops at MAX
    always_comb begin
        cnt_d = clr_i ? '0 : (inc_i && cnt_q != W'(MAX)) ? cnt_q + W'(1) : cnt_q;
    end
    assign hit_o = (cnt_q == W'(MAX - 1));
    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: shares the register-file write port between ALU and load writeback
module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input logic              clk,
    input logic              rst_n,
    reg_wb_arbiter_if.slave  bus
);
    state_e            state_q, state_d;
    src_e              src;
    logic              regw_q, regw_d;
    logic [ADDR_W-1:0] dr_q, dr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              inc, clr, hit, boost_go;
    // grant: loads first in NORM, ALU first in BOOST, nothing while held
    always_comb begin
        src = bus.hold ? SRC_NONE :
              (state_q == BOOST) ? (bus.alu_valid ? SRC_ALU : bus.mem_valid ? SRC_MEM : SRC_NONE) :
                                   (bus.mem_valid ? SRC_MEM : bus.alu_valid ? SRC_ALU : SRC_NONE);
    end
    assign bus.alu_ready = (src == SRC_ALU);
    assign bus.mem_ready = (src == SRC_MEM);
    // starvation bookkeeping and next state; hold freezes both
    always_comb begin
        inc      = ~bus.hold & (state_q == NORM) & bus.alu_valid & ~bus.alu_ready;
        boost_go = inc & hit;
        clr      = ~bus.hold & (bus.alu_ready | ~bus.alu_valid | boost_go);
        state_d  = bus.hold ? state_q : boost_go ? BOOST : NORM;
    end
    reg_wb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (inc),
        .clr_i (clr),
        .hit_o (hit)
    );
    // next write-port contents; writes to $0 are consumed but not enabled
    always_comb begin
        dr_d   = (src == SRC_ALU) ? bus.alu_dr   : (src == SRC_MEM) ? bus.mem_dr   : dr_q;
        data_d = (src == SRC_ALU) ? bus.alu_data : (src == SRC_MEM) ? bus.mem_data : data_q;
        regw_d = (src != SRC_NONE) && (dr_d != '0);
    end
    // FSM and registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NORM;
            regw_q  <= 1'b0;
            dr_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            regw_q  <= regw_d;
            dr_q    <= dr_d;
            data_q  <= data_d;
        end
    end
    assign bus.RegW       = regw_q;
    assign bus.DR         = dr_q;
    assign bus.data_write = data_q;
    assign bus.alu_boost  = (state_q == BOOST);
endmodule
